// File: rtl/m68k_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// m68k_bus_arbiter_if
// Bundles the 68000 bus-arbitration pins and the cycle-engine handshake that
// surround m68k_bus_arbiter.
//   M68K_BR_n, M68K_BGACK_n : external master request / acknowledge (async)
//   cyc_busy                : cycle engine is inside S1..S7 of a bridge cycle
//   wdog_clr                : one-clock pulse clearing ext_wdog
//   M68K_BG_n               : bus grant to the external master
//   bus_free                : cycle engine may start a new cycle
//   drive_en                : bridge address/data/strobe drivers enabled
//   arb_state               : arbiter state for the status register
//   ext_wdog                : sticky "external master held the bus too long"
// Modports:
//   master : the environment (external pins + cycle engine side)
//   slave  : the arbiter itself
// Handshake: the cycle engine may raise cyc_busy only on a clock where it
// sampled bus_free=1; the arbiter never asserts grant while cyc_busy=1.
// ---------------------------------------------------------------------------
interface m68k_bus_arbiter_if;
    logic       M68K_BR_n;
    logic       M68K_BGACK_n;
    logic       cyc_busy;
    logic       wdog_clr;
    logic       M68K_BG_n;
    logic       bus_free;
    logic       drive_en;
    logic [2:0] arb_state;
    logic       ext_wdog;

    modport master (
        output M68K_BR_n, M68K_BGACK_n, cyc_busy, wdog_clr,
        input  M68K_BG_n, bus_free, drive_en, arb_state, ext_wdog
    );

    modport slave (
        input  M68K_BR_n, M68K_BGACK_n, cyc_busy, wdog_clr,
        output M68K_BG_n, bus_free, drive_en, arb_state, ext_wdog
    );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// ---------------------------------------------------------------------------
// m68k_bus_arbiter
// 68000-side bus arbitration: synchronises BR_n/BGACK_n, answers with BG_n,
// gates the bridge cycle engine and releases the bridge drivers while an
// external master owns the bus. A watchdog flags long external ownership.
// Ports:
//   M68K_CLK     : CPU clock, all logic on the rising edge
//   M68K_RESET_n : asynchronous active-low reset
//   bus          : m68k_bus_arbiter_if.slave (pins + cycle-engine handshake)
// Parameters:
//   SYNC_STAGES  : synchroniser depth, 2..3
//   TURNAROUND   : clocks drivers stay released after reclaim, 1..15
//   WDOG_W       : external-ownership watchdog counter width
// ---------------------------------------------------------------------------
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 2,
    parameter int WDOG_W      = 16
) (
    input  logic                M68K_CLK,
    input  logic                M68K_RESET_n,
    m68k_bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_OWN     = 3'd0,
        ST_PEND    = 3'd1,
        ST_GRANTED = 3'd2,
        ST_EXT     = 3'd3,
        ST_RECLAIM = 3'd4
    } arb_state_e;

    localparam logic [3:0]        TA_LAST   = 4'(TURNAROUND - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
    localparam logic [WDOG_W-1:0] WDOG_PRE  = {{(WDOG_W-1){1'b1}}, 1'b0};
    localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_br_sync;
    logic [SYNC_STAGES-1:0] r_bgack_sync;
    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [3:0]             r_ta_cnt;
    logic [WDOG_W-1:0]      r_wdog_cnt;
    logic                   r_ext_wdog;
    logic                   r_bg_n;
    logic                   r_drive_en;
    logic                   r_bus_free;
    logic                   w_br;
    logic                   w_bgack;
    logic                   w_br_nxt;
    arb_state_e             w_grant_tgt;

    // Synchronisers hold the active-high sense, so 0 means "not asserted".
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            r_br_sync    <= '0;
            r_bgack_sync <= '0;
        end else begin
            r_br_sync    <= {r_br_sync[SYNC_STAGES-2:0], ~bus.M68K_BR_n};
            r_bgack_sync <= {r_bgack_sync[SYNC_STAGES-2:0], ~bus.M68K_BGACK_n};
        end
    end

    assign w_br     = r_br_sync[SYNC_STAGES-1];
    assign w_bgack  = r_bgack_sync[SYNC_STAGES-1];
    // Value w_br takes after this edge; lets bus_free be registered without
    // adding a clock of latency.
    assign w_br_nxt = r_br_sync[SYNC_STAGES-2];

    // Any grant request is deferred to PEND while a bridge cycle is running.
    assign w_grant_tgt = bus.cyc_busy ? ST_PEND : ST_GRANTED;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OWN: begin
                if (w_br) w_state_nxt = w_grant_tgt;
            end
            ST_PEND: begin
                if (!bus.cyc_busy) w_state_nxt = ST_GRANTED;
            end
            ST_GRANTED: begin
                if (w_bgack)   w_state_nxt = ST_EXT;
                else if (!w_br) w_state_nxt = ST_RECLAIM;
            end
            ST_EXT: begin
                if (!w_bgack) w_state_nxt = w_br ? w_grant_tgt : ST_RECLAIM;
            end
            ST_RECLAIM: begin
                if (w_br)                     w_state_nxt = w_grant_tgt;
                else if (r_ta_cnt == TA_LAST) w_state_nxt = ST_OWN;
            end
            default: w_state_nxt = ST_OWN;
        endcase
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            r_state    <= ST_OWN;
            r_ta_cnt   <= '0;
            r_wdog_cnt <= '0;
            r_ext_wdog <= 1'b0;
            r_bg_n     <= 1'b1;
            r_drive_en <= 1'b1;
            r_bus_free <= 1'b1;
        end else begin
            r_state <= w_state_nxt;

            // Turnaround counter only runs while staying in RECLAIM.
            if (r_state == ST_RECLAIM && w_state_nxt == ST_RECLAIM)
                r_ta_cnt <= r_ta_cnt + 4'd1;
            else
                r_ta_cnt <= '0;

            // Held at zero outside EXT, so every entry starts from zero.
            if (r_state == ST_EXT) begin
                if (r_wdog_cnt != WDOG_MAX) r_wdog_cnt <= r_wdog_cnt + WDOG_ONE;
            end else begin
                r_wdog_cnt <= '0;
            end

            if (bus.wdog_clr)
                r_ext_wdog <= 1'b0;
            else if (r_state == ST_EXT && r_wdog_cnt == WDOG_PRE)
                r_ext_wdog <= 1'b1;

            r_bg_n     <= (w_state_nxt != ST_GRANTED);
            r_drive_en <= (w_state_nxt == ST_OWN) || (w_state_nxt == ST_PEND);
            r_bus_free <= (w_state_nxt == ST_OWN) && !w_br_nxt;
        end
    end

    assign bus.M68K_BG_n = r_bg_n;
    assign bus.drive_en  = r_drive_en;
    assign bus.bus_free  = r_bus_free;
    assign bus.arb_state = r_state;
    assign bus.ext_wdog  = r_ext_wdog;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_m68k_bus_arbiter
// Directed scenarios for the arbitration handshake plus a randomized run
// compared cycle by cycle against a behavioural model of the arbiter rules.
// ---------------------------------------------------------------------------
module tb_m68k_bus_arbiter;

    localparam int SYNC = 2;
    localparam int TA   = 2;
    localparam int WW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    m68k_bus_arbiter_if bus_if ();

    m68k_bus_arbiter #(
        .SYNC_STAGES (SYNC),
        .TURNAROUND  (TA),
        .WDOG_W      (WW)
    ) dut (
        .M68K_CLK     (clk),
        .M68K_RESET_n (rst_n),
        .bus          (bus_if)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Advance n clocks; leaves time at 1 unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    // Ownership modes use the status encodings: 0 bridge owns, 1 waiting for
    // bridge cycle, 2 grant offered, 3 external owner, 4 returning the bus.
    int          m_mode;
    int          m_reclaim_spent;
    int          m_ext_clocks;
    bit          m_flag;
    bit          br_hist[$];
    bit          bgack_hist[$];
    logic [6:0]  exp_q[$];

    task automatic model_reset();
        m_mode = 0;
        m_reclaim_spent = 0;
        m_ext_clocks = 0;
        m_flag = 1'b0;
        br_hist.delete();
        bgack_hist.delete();
        exp_q.delete();
        for (int i = 0; i < SYNC; i++) begin
            br_hist.push_back(1'b0);
            bgack_hist.push_back(1'b0);
        end
    endtask

    // Called once per rising edge with the pin values present at that edge.
    task automatic model_edge(input bit req, input bit ack, input bit busy, input bit clr);
        bit br_seen;
        bit ack_seen;
        int nm;
        int want_grant;
        br_seen  = br_hist.pop_front();
        ack_seen = bgack_hist.pop_front();
        br_hist.push_back(req);
        bgack_hist.push_back(ack);
        want_grant = busy ? 1 : 2;

        if (m_mode == 3) m_ext_clocks++;
        if (clr) m_flag = 1'b0;
        else if (m_mode == 3 && m_ext_clocks == (1 << WW) - 1) m_flag = 1'b1;

        nm = m_mode;
        if (m_mode == 0) begin
            if (br_seen) nm = want_grant;
        end else if (m_mode == 1) begin
            if (!busy) nm = 2;
        end else if (m_mode == 2) begin
            if (ack_seen) nm = 3;
            else if (!br_seen) nm = 4;
        end else if (m_mode == 3) begin
            if (!ack_seen) nm = br_seen ? want_grant : 4;
        end else begin
            if (br_seen) nm = want_grant;
            else begin
                m_reclaim_spent++;
                if (m_reclaim_spent == TA) nm = 0;
            end
        end
        if (nm == 3 && m_mode != 3) m_ext_clocks = 0;
        if (nm == 4 && m_mode != 4) m_reclaim_spent = 0;
        m_mode = nm;

        exp_q.push_back({1'(m_mode != 2), 1'(m_mode == 0 && !br_hist[0]),
                         1'(m_mode <= 1), 3'(m_mode), m_flag});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus_if.M68K_BG_n !== 1'b1) begin errors++; $display("FAIL reset_bg_n got %b want 1", bus_if.M68K_BG_n); end
        checks++; if (bus_if.bus_free !== 1'b1) begin errors++; $display("FAIL reset_bus_free got %b want 1", bus_if.bus_free); end
        checks++; if (bus_if.drive_en !== 1'b1) begin errors++; $display("FAIL reset_drive_en got %b want 1", bus_if.drive_en); end
        checks++; if (bus_if.arb_state !== 3'd0) begin errors++; $display("FAIL reset_arb_state got %0d want 0", bus_if.arb_state); end
        checks++; if (bus_if.ext_wdog !== 1'b0) begin errors++; $display("FAIL reset_ext_wdog got %b want 0", bus_if.ext_wdog); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_grant();
        bus_if.cyc_busy  = 1'b0;
        bus_if.M68K_BR_n = 1'b0;
        step(1);
        checks++; if (bus_if.bus_free !== 1'b1) begin errors++; $display("FAIL grant_bus_free_c1 got %b want 1", bus_if.bus_free); end
        step(1);
        checks++; if (bus_if.bus_free !== 1'b0) begin errors++; $display("FAIL grant_bus_free_c2 got %b want 0", bus_if.bus_free); end
        checks++; if (bus_if.M68K_BG_n !== 1'b1) begin errors++; $display("FAIL grant_bg_n_c2 got %b want 1", bus_if.M68K_BG_n); end
        step(1);
        checks++; if (bus_if.M68K_BG_n !== 1'b0) begin errors++; $display("FAIL grant_bg_n_c3 got %b want 0", bus_if.M68K_BG_n); end
        checks++; if (bus_if.drive_en !== 1'b0) begin errors++; $display("FAIL grant_drive_en_c3 got %b want 0", bus_if.drive_en); end
        checks++; if (bus_if.arb_state !== 3'd2) begin errors++; $display("FAIL grant_state_c3 got %0d want 2", bus_if.arb_state); end
        bus_if.M68K_BGACK_n = 1'b0;
        bus_if.M68K_BR_n    = 1'b1;
        step(2);
        checks++; if (bus_if.M68K_BG_n !== 1'b0) begin errors++; $display("FAIL ack_bg_n_c2 got %b want 0", bus_if.M68K_BG_n); end
        step(1);
        checks++; if (bus_if.M68K_BG_n !== 1'b1) begin errors++; $display("FAIL ack_bg_n_c3 got %b want 1", bus_if.M68K_BG_n); end
        checks++; if (bus_if.arb_state !== 3'd3) begin errors++; $display("FAIL ack_state_c3 got %0d want 3", bus_if.arb_state); end
    endtask

    task automatic test_release();
        bus_if.M68K_BGACK_n = 1'b1;
        step(2);
        checks++; if (bus_if.arb_state !== 3'd3) begin errors++; $display("FAIL rel_state_c2 got %0d want 3", bus_if.arb_state); end
        step(1);
        checks++; if (bus_if.arb_state !== 3'd4) begin errors++; $display("FAIL rel_state_c3 got %0d want 4", bus_if.arb_state); end
        checks++; if (bus_if.drive_en !== 1'b0) begin errors++; $display("FAIL rel_drive_en_c3 got %b want 0", bus_if.drive_en); end
        step(1);
        checks++; if (bus_if.arb_state !== 3'd4) begin errors++; $display("FAIL rel_state_c4 got %0d want 4", bus_if.arb_state); end
        checks++; if (bus_if.bus_free !== 1'b0) begin errors++; $display("FAIL rel_bus_free_c4 got %b want 0", bus_if.bus_free); end
        step(1);
        checks++; if (bus_if.arb_state !== 3'd0) begin errors++; $display("FAIL rel_state_c5 got %0d want 0", bus_if.arb_state); end
        checks++; if (bus_if.drive_en !== 1'b1) begin errors++; $display("FAIL rel_drive_en_c5 got %b want 1", bus_if.drive_en); end
        checks++; if (bus_if.bus_free !== 1'b1) begin errors++; $display("FAIL rel_bus_free_c5 got %b want 1", bus_if.bus_free); end
    endtask

    task automatic test_busy_defer();
        bus_if.cyc_busy  = 1'b1;
        bus_if.M68K_BR_n = 1'b0;
        step(2);
        checks++; if (bus_if.bus_free !== 1'b0) begin errors++; $display("FAIL busy_bus_free got %b want 0", bus_if.bus_free); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if (bus_if.arb_state !== 3'd1) begin errors++; $display("FAIL busy_state_%0d got %0d want 1", i, bus_if.arb_state); end
            checks++; if (bus_if.M68K_BG_n !== 1'b1) begin errors++; $display("FAIL busy_bg_n_%0d got %b want 1", i, bus_if.M68K_BG_n); end
            checks++; if (bus_if.drive_en !== 1'b1) begin errors++; $display("FAIL busy_drive_en_%0d got %b want 1", i, bus_if.drive_en); end
        end
        bus_if.cyc_busy = 1'b0;
        step(1);
        checks++; if (bus_if.M68K_BG_n !== 1'b0) begin errors++; $display("FAIL busy_end_bg_n got %b want 0", bus_if.M68K_BG_n); end
        checks++; if (bus_if.arb_state !== 3'd2) begin errors++; $display("FAIL busy_end_state got %0d want 2", bus_if.arb_state); end
    endtask

    task automatic test_withdrawn();
        bus_if.M68K_BR_n = 1'b1;
        step(2);
        checks++; if (bus_if.M68K_BG_n !== 1'b0) begin errors++; $display("FAIL wd_bg_n_c2 got %b want 0", bus_if.M68K_BG_n); end
        step(1);
        checks++; if (bus_if.M68K_BG_n !== 1'b1) begin errors++; $display("FAIL wd_bg_n_c3 got %b want 1", bus_if.M68K_BG_n); end
        checks++; if (bus_if.arb_state !== 3'd4) begin errors++; $display("FAIL wd_state_c3 got %0d want 4", bus_if.arb_state); end
        step(2);
        checks++; if (bus_if.arb_state !== 3'd0) begin errors++; $display("FAIL wd_state_c5 got %0d want 0", bus_if.arb_state); end
        checks++; if (bus_if.ext_wdog !== 1'b0) begin errors++; $display("FAIL wd_ext_wdog got %b want 0", bus_if.ext_wdog); end
    endtask

    task automatic test_watchdog();
        bus_if.M68K_BR_n = 1'b0;
        step(3);
        bus_if.M68K_BGACK_n = 1'b0;
        bus_if.M68K_BR_n    = 1'b1;
        step(3);
        checks++; if (bus_if.arb_state !== 3'd3) begin errors++; $display("FAIL wdog_state_entry got %0d want 3", bus_if.arb_state); end
        step(14);
        checks++; if (bus_if.ext_wdog !== 1'b0) begin errors++; $display("FAIL wdog_early got %b want 0", bus_if.ext_wdog); end
        step(1);
        checks++; if (bus_if.ext_wdog !== 1'b1) begin errors++; $display("FAIL wdog_set got %b want 1", bus_if.ext_wdog); end
        checks++; if (bus_if.arb_state !== 3'd3) begin errors++; $display("FAIL wdog_no_reclaim got %0d want 3", bus_if.arb_state); end
        step(2);
        bus_if.M68K_BGACK_n = 1'b1;
        step(5);
        checks++; if (bus_if.arb_state !== 3'd0) begin errors++; $display("FAIL wdog_released_state got %0d want 0", bus_if.arb_state); end
        checks++; if (bus_if.ext_wdog !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b want 1", bus_if.ext_wdog); end
        bus_if.wdog_clr = 1'b1;
        step(1);
        bus_if.wdog_clr = 1'b0;
        checks++; if (bus_if.ext_wdog !== 1'b0) begin errors++; $display("FAIL wdog_clear got %b want 0", bus_if.ext_wdog); end
        step(1);
        checks++; if (bus_if.ext_wdog !== 1'b0) begin errors++; $display("FAIL wdog_stays_clear got %b want 0", bus_if.ext_wdog); end
    endtask

    task automatic test_reset_mid_ext();
        bus_if.M68K_BR_n = 1'b0;
        step(3);
        bus_if.M68K_BGACK_n = 1'b0;
        bus_if.M68K_BR_n    = 1'b1;
        step(19);
        checks++; if (bus_if.ext_wdog !== 1'b1) begin errors++; $display("FAIL rst_pre_wdog got %b want 1", bus_if.ext_wdog); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.M68K_BG_n !== 1'b1) begin errors++; $display("FAIL rst_mid_bg_n got %b want 1", bus_if.M68K_BG_n); end
        checks++; if (bus_if.drive_en !== 1'b1) begin errors++; $display("FAIL rst_mid_drive_en got %b want 1", bus_if.drive_en); end
        checks++; if (bus_if.arb_state !== 3'd0) begin errors++; $display("FAIL rst_mid_state got %0d want 0", bus_if.arb_state); end
        checks++; if (bus_if.ext_wdog !== 1'b0) begin errors++; $display("FAIL rst_mid_wdog got %b want 0", bus_if.ext_wdog); end
        bus_if.M68K_BGACK_n = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(3);
        checks++; if (bus_if.bus_free !== 1'b1) begin errors++; $display("FAIL rst_after_bus_free got %b want 1", bus_if.bus_free); end
    endtask

    task automatic test_random();
        logic [6:0] got;
        logic [6:0] exp;
        rst_n = 1'b0;
        bus_if.M68K_BR_n    = 1'b1;
        bus_if.M68K_BGACK_n = 1'b1;
        bus_if.cyc_busy     = 1'b0;
        bus_if.wdog_clr     = 1'b0;
        step(2);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0)  bus_if.M68K_BR_n    = ~bus_if.M68K_BR_n;
            if ($urandom_range(0, 11) == 0) bus_if.M68K_BGACK_n = ~bus_if.M68K_BGACK_n;
            if ($urandom_range(0, 3) == 0)  bus_if.cyc_busy     = ~bus_if.cyc_busy;
            bus_if.wdog_clr = ($urandom_range(0, 29) == 0);
            @(posedge clk);
            model_edge(~bus_if.M68K_BR_n, ~bus_if.M68K_BGACK_n, bus_if.cyc_busy, bus_if.wdog_clr);
            #1;
            got = {bus_if.M68K_BG_n, bus_if.bus_free, bus_if.drive_en, bus_if.arb_state, bus_if.ext_wdog};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle_%0d {bg_n,bus_free,drive_en,state,wdog} got %b want %b", c, got, exp);
            end
        end
        bus_if.wdog_clr = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus_if.M68K_BR_n    = 1'b1;
        bus_if.M68K_BGACK_n = 1'b1;
        bus_if.cyc_busy     = 1'b0;
        bus_if.wdog_clr     = 1'b0;
        test_reset();
        test_idle_grant();
        test_release();
        test_busy_defer();
        test_withdrawn();
        test_watchdog();
        test_reset_mid_ext();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
